// File: rtl/fb_scan_scaler.sv
// fb_scan_scaler: VGA timing, scaled framebuffer addressing, palette lookup and
// double-buffered page select, with a 2-stage pixel pipeline gated by pix_en.
module fb_scan_scaler #(
    parameter int H_ACTIVE = 640,
    parameter int H_FP     = 16,
    parameter int H_SYNC   = 96,
    parameter int H_BP     = 48,
    parameter int V_ACTIVE = 480,
    parameter int V_FP     = 10,
    parameter int V_SYNC   = 2,
    parameter int V_BP     = 33,
    parameter int SCALE    = 4,
    parameter int PIX_W    = 3,
    parameter int ADDR_W   = 16
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              pix_en,
    input  logic              page_sel,
    output logic [ADDR_W-1:0] rd_addr,
    input  logic [PIX_W-1:0]  rd_data,
    input  logic              pal_we,
    input  logic [PIX_W-1:0]  pal_idx,
    input  logic [23:0]       pal_rgb,
    output logic [7:0]        red,
    output logic [7:0]        green,
    output logic [7:0]        blue,
    output logic              hsync,
    output logic              vsync,
    output logic              blank_n,
    output logic              frame_start
);
    localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
    localparam int SRC_W   = H_ACTIVE / SCALE;
    localparam int SRC_H   = V_ACTIVE / SCALE;
    localparam int XW      = $clog2(H_TOTAL);
    localparam int YW      = $clog2(V_TOTAL);
    localparam int SW      = SCALE > 1 ? $clog2(SCALE) : 1;

    localparam logic [XW-1:0]     HA  = XW'(H_ACTIVE);
    localparam logic [XW-1:0]     HT1 = XW'(H_TOTAL - 1);
    localparam logic [XW-1:0]     HSB = XW'(H_ACTIVE + H_FP);
    localparam logic [XW-1:0]     HSE = XW'(H_ACTIVE + H_FP + H_SYNC);
    localparam logic [YW-1:0]     VA  = YW'(V_ACTIVE);
    localparam logic [YW-1:0]     VT1 = YW'(V_TOTAL - 1);
    localparam logic [YW-1:0]     VSB = YW'(V_ACTIVE + V_FP);
    localparam logic [YW-1:0]     VSE = YW'(V_ACTIVE + V_FP + V_SYNC);
    localparam logic [SW-1:0]     S1  = SW'(SCALE - 1);
    localparam logic [ADDR_W-1:0] ROW = ADDR_W'(SRC_W);
    localparam logic [ADDR_W-1:0] PB  = ADDR_W'(SRC_W * SRC_H);

    logic [XW-1:0]     x, x_n;
    logic [YW-1:0]     y, y_n;
    logic [SW-1:0]     sx, sx_n, sy, sy_n;
    logic [ADDR_W-1:0] cx, cx_n, row_base, row_base_n;
    logic              page, page_n;
    logic              line_end, frame_n, act_n;
    logic              act0, hs0, vs0, fs0;
    logic              act1, hs1, vs1, fs1;
    logic [23:0]       pal [2**PIX_W];

    // Next-pixel state is computed up front so rd_addr can be registered for the pixel it serves.
    always_comb begin
        line_end   = x == HT1;
        x_n        = line_end ? '0 : x + 1'b1;
        y_n        = line_end ? (y == VT1 ? '0 : y + 1'b1) : y;
        frame_n    = x_n == '0 && y_n == '0;
        sx_n       = line_end ? '0 : (x < HA ? (sx == S1 ? '0 : sx + 1'b1) : sx);
        cx_n       = line_end ? '0 : (x < HA && sx == S1 ? cx + 1'b1 : cx);
        page_n     = frame_n ? page_sel : page;
        sy_n       = frame_n ? '0 : (line_end && y < VA ? (sy == S1 ? '0 : sy + 1'b1) : sy);
        row_base_n = frame_n ? (page_n ? PB : '0)
                   : (line_end && y < VA && sy == S1 ? row_base + ROW : row_base);
        act_n      = x_n < HA && y_n < VA;
        act0       = x < HA && y < VA;
        hs0        = !(x >= HSB && x < HSE);
        vs0        = !(y >= VSB && y < VSE);
        fs0        = x == '0 && y == '0;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            x        <= '0;
            y        <= '0;
            sx       <= '0;
            sy       <= '0;
            cx       <= '0;
            row_base <= '0;
            page     <= 1'b0;
            rd_addr  <= '0;
            act1     <= 1'b0;
            hs1      <= 1'b1;
            vs1      <= 1'b1;
            fs1      <= 1'b0;
            red      <= '0;
            green    <= '0;
            blue     <= '0;
            hsync    <= 1'b1;
            vsync    <= 1'b1;
            blank_n  <= 1'b0;
            frame_start <= 1'b0;
        end else if (pix_en) begin
            x        <= x_n;
            y        <= y_n;
            sx       <= sx_n;
            sy       <= sy_n;
            cx       <= cx_n;
            row_base <= row_base_n;
            page     <= page_n;
            rd_addr  <= act_n ? row_base_n + cx_n : rd_addr;
            act1     <= act0;
            hs1      <= hs0;
            vs1      <= vs0;
            fs1      <= fs0;
            {red, green, blue} <= act1 ? pal[rd_data] : 24'h0;
            hsync    <= hs1;
            vsync    <= vs1;
            blank_n  <= act1;
            frame_start <= fs1;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < 2**PIX_W; i++) pal[i] <= (i == 1) ? 24'h0000FA : 24'h0;
        end else if (pal_we) begin
            pal[pal_idx] <= pal_rgb;
        end
    end
endmodule

// File: tb/tb_fb_scan_scaler.sv
// tb_fb_scan_scaler: directed bench for fb_scan_scaler on a shrunken 24x12 raster
// (16x8 active, SCALE 4, 4x2 source), checking every pipeline step against expectations.
module tb_fb_scan_scaler;
    localparam int HA = 16, HFP = 2, HS = 3, HBP = 3;
    localparam int VA = 8, VFP = 1, VS = 2, VBP = 1;
    localparam int S = 4, PW = 3, AW = 8;
    localparam int HT = 24, VT = 12, FR = 288, SRCW = 4, PB = 8;

    logic          clk = 0, reset = 0, pix_en = 0, page_sel = 0, pal_we = 0;
    logic [PW-1:0] rd_data = '0, pal_idx = '0;
    logic [23:0]   pal_rgb = '0;
    logic [AW-1:0] rd_addr;
    logic [7:0]    red, green, blue;
    logic          hsync, vsync, blank_n, frame_start;
    int            checks = 0, failures = 0, cyc = 0;
    logic [23:0]   pal_m [8];

    fb_scan_scaler #(
        .H_ACTIVE(HA), .H_FP(HFP), .H_SYNC(HS), .H_BP(HBP),
        .V_ACTIVE(VA), .V_FP(VFP), .V_SYNC(VS), .V_BP(VBP),
        .SCALE(S), .PIX_W(PW), .ADDR_W(AW)
    ) dut (
        .clk(clk), .reset(reset), .pix_en(pix_en), .page_sel(page_sel),
        .rd_addr(rd_addr), .rd_data(rd_data),
        .pal_we(pal_we), .pal_idx(pal_idx), .pal_rgb(pal_rgb),
        .red(red), .green(green), .blue(blue),
        .hsync(hsync), .vsync(vsync), .blank_n(blank_n), .frame_start(frame_start)
    );

    always #5 clk = ~clk;

    // Synchronous-read RAM whose contents are addr[2:0].
    always @(posedge clk) if (pix_en) rd_data <= rd_addr[2:0];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s cyc=%0d got=%0h expected=%0h", tag, cyc, obs, exp);
        end
    endtask

    function automatic int exp_addr(int p);
        int ox = p % HT, oy = (p / HT) % VT;
        return ((p / FR) >= 1 ? PB : 0) + (oy / S) * SRCW + ox / S;
    endfunction

    function automatic logic is_active(int p);
        return (p % HT) < HA && ((p / HT) % VT) < VA;
    endfunction

    function automatic logic [27:0] exp_out(int p);
        int  ox, oy;
        logic act;
        if (p < 0) return {24'h0, 4'b1100};
        ox  = p % HT;
        oy  = (p / HT) % VT;
        act = is_active(p);
        return {act ? pal_m[exp_addr(p) % 8] : 24'h0,
                !(ox >= HA + HFP && ox < HA + HFP + HS),
                !(oy >= VA + VFP && oy < VA + VFP + VS),
                act, ox == 0 && oy == 0};
    endfunction

    function automatic logic [31:0] obs_out();
        return {4'h0, red, green, blue, hsync, vsync, blank_n, frame_start};
    endfunction

    task automatic step(input logic en);
        pix_en = en;
        @(posedge clk);
        #1;
        if (en) cyc++;
        chk("out", obs_out(), {4'h0, exp_out(cyc - 2)});
        if (is_active(cyc)) chk("addr", 32'(rd_addr), 32'(exp_addr(cyc)));
    endtask

    task automatic run_to(input int c);
        while (cyc < c) step(1'b1);
    endtask

    task automatic reset_pal_model();
        for (int i = 0; i < 8; i++) pal_m[i] = (i == 1) ? 24'h0000FA : 24'h0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog timeout checks=%0d", checks);
        $fatal(1, "watchdog");
    end

    initial begin
        reset_pal_model();
        reset  = 0;
        pix_en = 1;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_out", obs_out(), {8'h0, 24'h0, 4'b1100} >> 4 << 4 | 32'hC);
        chk("rst_addr", 32'(rd_addr), 0);
        pix_en = 0;
        reset  = 1;
        for (int i = 0; i < 8; i++) begin
            if (i != 1) begin
                pal_we  = 1;
                pal_idx = 3'(i);
                pal_rgb = {8'(i * 30), 16'h0};
                @(posedge clk);
                #1;
                pal_m[i] = pal_rgb;
            end
        end
        pal_we = 0;
        chk("hold_addr", 32'(rd_addr), 0);
        chk("hold_blank", 32'(blank_n), 0);
        step(1'b1);
        chk("fs_early", 32'(frame_start), 0);
        step(1'b1);
        chk("fs_first", 32'(frame_start), 1);
        chk("blank_first", 32'(blank_n), 1);
        run_to(6);
        chk("blue_p4", 32'(blue), 32'hFA);
        run_to(10);
        chk("red_p8", 32'(red), 60);
        run_to(19);
        chk("hs_before", 32'(hsync), 1);
        run_to(20);
        chk("hs_begin", 32'(hsync), 0);
        run_to(22);
        chk("hs_last", 32'(hsync), 0);
        run_to(23);
        chk("hs_end", 32'(hsync), 1);
        run_to(26);
        chk("line1_blank", 32'(blank_n), 1);
        chk("line1_fs", 32'(frame_start), 0);
        run_to(96);
        chk("addr_line4", 32'(rd_addr), 4);
        run_to(144);
        page_sel = 1;
        run_to(183);
        chk("addr_last_f0", 32'(rd_addr), 7);
        run_to(217);
        chk("vs_before", 32'(vsync), 1);
        run_to(218);
        chk("vs_begin", 32'(vsync), 0);
        run_to(265);
        chk("vs_last", 32'(vsync), 0);
        run_to(266);
        chk("vs_end", 32'(vsync), 1);
        run_to(288);
        chk("addr_first_f1", 32'(rd_addr), 8);
        for (int i = 0; i < 30; i++) begin
            step(1'b0);
            step(1'b1);
        end
        run_to(471);
        chk("addr_last_f1", 32'(rd_addr), 15);
        run_to(606);
        pal_we  = 1;
        pal_idx = 3'd1;
        pal_rgb = 24'hFFFF00;
        step(1'b1);
        chk("pal_old_blue", 32'(blue), 32'hFA);
        chk("pal_old_red", 32'(red), 0);
        pal_m[1] = 24'hFFFF00;
        pal_we   = 0;
        step(1'b1);
        chk("pal_new_red", 32'(red), 32'hFF);
        chk("pal_new_blue", 32'(blue), 0);
        run_to(634);
        page_sel = 0;
        reset    = 0;
        #1;
        reset_pal_model();
        chk("async_rst_out", obs_out(), 32'hC);
        chk("async_rst_addr", 32'(rd_addr), 0);
        repeat (3) @(posedge clk);
        #1;
        chk("rst_held_out", obs_out(), 32'hC);
        reset = 1;
        cyc   = 0;
        step(1'b1);
        chk("restart_fs_early", 32'(frame_start), 0);
        step(1'b1);
        chk("restart_fs", 32'(frame_start), 1);
        run_to(40);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
